// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// Oversampling UART receiver front end. Synchronises the serial line, divides
// clk into an oversample tick, majority-votes each bit around mid-bit, checks
// start/parity/stop framing and hands good bytes to a valid/ready consumer.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   rx_i                asynchronous serial line (idle high)
//   cfg_en_i            receiver enable; 0 forces IDLE
//   cfg_div_i           clk cycles per oversample tick (0 behaves as 1)
//   cfg_parity_en_i     parity bit follows the data bits
//   cfg_parity_odd_i    1 = odd parity, 0 = even parity
//   cfg_stop_bits_i     0 = one stop bit, 1 = two stop bits
//   rx_data_o           received byte
//   rx_valid_o          rx_data_o holds an undelivered byte
//   rx_ready_i          consumer accepts the byte
//   err_frame_o         1-cycle pulse: stop bit sampled 0
//   err_parity_o        1-cycle pulse: parity mismatch
//   err_overrun_o       1-cycle pulse: good byte dropped, holding register full
//   busy_o              receiver is not IDLE
module uart_rx_sampler #(
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_parity_en_i,
  input  logic                 cfg_parity_odd_i,
  input  logic                 cfg_stop_bits_i,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 err_frame_o,
  output logic                 err_parity_o,
  output logic                 err_overrun_o,
  output logic                 busy_o
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] MID        = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] SAMP_FIRST = OS_W'(OVERSAMPLE / 2 - 2);
  localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BREAK
  } state_t;

  state_t                 state, state_d;
  logic                   rx_s1, rx_s2, rx_prev;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [DIV_WIDTH-1:0]   div_reload;
  logic [OS_W-1:0]        os_cnt;
  logic [2:0]             maj_sr;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic                   par_err;

  logic tick, mid, bit_val;
  logic start_go, shift_en, par_eval, deliver, frame_err;
  logic held_blocked, load;

  assign div_reload = (cfg_div_i == '0) ? '0 : cfg_div_i - DIV_WIDTH'(1);
  assign tick       = (div_cnt == '0);
  assign mid        = tick && (os_cnt == MID);

  // At the mid-sample tick the third sample is still on rx_s2, so vote on the
  // two older register entries plus the live synchronised value.
  assign bit_val = (maj_sr[1] & maj_sr[0]) | (maj_sr[1] & rx_s2) | (maj_sr[0] & rx_s2);

  assign held_blocked = rx_valid_o && !rx_ready_i;
  assign load         = deliver && !par_err && !held_blocked;
  assign busy_o       = (state != IDLE);

  always_comb begin
    state_d   = state;
    start_go  = 1'b0;
    shift_en  = 1'b0;
    par_eval  = 1'b0;
    deliver   = 1'b0;
    frame_err = 1'b0;
    if (!cfg_en_i) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s2) begin
            state_d  = START;
            start_go = 1'b1;
          end
        end
        START: begin
          if (mid) state_d = bit_val ? IDLE : DATA;
        end
        DATA: begin
          if (mid) begin
            shift_en = 1'b1;
            if (bit_idx == 3'd7) state_d = cfg_parity_en_i ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (mid) begin
            par_eval = 1'b1;
            state_d  = STOP1;
          end
        end
        STOP1, STOP2: begin
          if (mid) begin
            if (!bit_val) begin
              frame_err = 1'b1;
              state_d   = BREAK;
            end else if (state == STOP1 && cfg_stop_bits_i) begin
              state_d = STOP2;
            end else begin
              deliver = 1'b1;
              state_d = IDLE;
            end
          end
        end
        BREAK: begin
          if (rx_s2) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_prev       <= 1'b1;
      div_cnt       <= '0;
      os_cnt        <= '0;
      maj_sr        <= '1;
      bit_idx       <= '0;
      shreg         <= '0;
      par_err       <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      err_frame_o   <= 1'b0;
      err_parity_o  <= 1'b0;
      err_overrun_o <= 1'b0;
    end else begin
      state   <= state_d;
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;

      if (start_go) begin
        // Restart bit timing from the detected edge.
        div_cnt <= '0;
        os_cnt  <= '0;
        bit_idx <= '0;
        par_err <= 1'b0;
      end else begin
        div_cnt <= tick ? div_reload : div_cnt - DIV_WIDTH'(1);
        if (tick) begin
          os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
          if (os_cnt >= SAMP_FIRST && os_cnt <= MID) maj_sr <= {maj_sr[1:0], rx_s2};
        end
      end

      if (shift_en) begin
        shreg   <= {bit_val, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (par_eval) par_err <= (bit_val != ((^shreg) ^ cfg_parity_odd_i));

      err_frame_o   <= frame_err;
      err_parity_o  <= deliver && par_err;
      err_overrun_o <= deliver && !par_err && held_blocked;

      if (load) begin
        rx_data_o  <= shreg;
        rx_valid_o <= 1'b1;
      end else if (rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
Oversampling UART receiver front end. Sits between the uart_rx_i pad and the peripheral's RX FIFO.
- Synchronises the asynchronous line and generates a programmable 16x baud tick.
- Majority-votes each bit and checks start, parity and stop framing.
- Presents each good byte on a valid/ready interface that connects directly to the FIFO write side.
- Reports frame, parity and overrun errors as single-cycle pulses for the control/status logic.

Parameters:
- DIV_WIDTH, 16, width of the baud divisor input.
- OVERSAMPLE, 16, ticks per bit. Must be a power of two and at least 8.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- rx_i  input  1  asynchronous serial line; idle level is 1.
- cfg_en_i  input  1  receiver enable. 0 forces IDLE.
- cfg_div_i  input  DIV_WIDTH  clk cycles per oversample tick. 0 is treated as 1.
- cfg_parity_en_i  input  1  a parity bit follows the data bits.
- cfg_parity_odd_i  input  1  1 = odd parity, 0 = even parity.
- cfg_stop_bits_i  input  1  0 = one stop bit, 1 = two stop bits.
- rx_data_o  output  8  received byte.
- rx_valid_o  output  1  rx_data_o holds an undelivered byte.
- rx_ready_i  input  1  consumer accepts the byte.
- err_frame_o  output  1  1-cycle pulse: a stop bit sampled 0.
- err_parity_o  output  1  1-cycle pulse: parity mismatch.
- err_overrun_o  output  1  1-cycle pulse: a good byte was dropped because the holding register was full.
- busy_o  output  1  state is not IDLE.

Behaviour:
- **Reset values:** rx_data_o=0x00, rx_valid_o=0, all err_* outputs=0, busy_o=0, state=IDLE. Both sync flops and the majority shift register reset to 1; all counters reset to 0. Reset aborts any frame in progress with no error pulse.
- **Synchroniser:** 2-flop synchroniser on rx_i, giving 2 cycles of latency. All decisions use the synchronised value.
- **Baud tick:** a divisor counter reloads with max(cfg_div_i,1)-1 and pulses tick when it reaches 0. Tick period is max(cfg_div_i,1) cycles. A changed cfg_div_i takes effect at the next reload. The divisor counter is cleared on the IDLE->START transition so bit timing aligns to the detected edge.
- **Sampling:** a 3-deep shift register captures the synchronised line on ticks OVERSAMPLE/2-2 .. OVERSAMPLE/2. The bit value is the majority of those 3 samples, evaluated at tick OVERSAMPLE/2 (the mid-sample). The tick counter wraps from OVERSAMPLE-1 to 0.
- **States:**
  - IDLE: on a synchronised 1->0 transition with cfg_en_i=1, go to START.
  - START: at mid-sample, majority 1 means a glitch; return to IDLE with no pulse. Majority 0 goes to DATA with bit index 0.
  - DATA: 8 bits, LSB first, one per OVERSAMPLE ticks. After bit 7, go to PARITY if cfg_parity_en_i=1, otherwise STOP1.
  - PARITY: at mid-sample, compare the sampled bit against the XOR of the data bits. The expected bit is inverted when odd parity is selected. The result is latched as a parity-error flag.
  - STOP1: evaluated at mid-sample.
    - Stop bit 0: pulse err_frame_o, drop the byte, go to BREAK.
    - Stop bit 1 and cfg_stop_bits_i=1: go to STOP2.
    - Stop bit 1 and cfg_stop_bits_i=0: deliver the byte and go to IDLE. IDLE is entered at the mid-sample, not the bit end, so resync happens early.
  - STOP2: same checks as STOP1, then go to IDLE.
  - BREAK: wait until the synchronised line is 1, then go to IDLE.
- **Delivery:** on the final good stop mid-sample:
  - If the parity flag is set: pulse err_parity_o and drop the byte.
  - Else if rx_valid_o=1 and rx_ready_i=0 in that cycle: pulse err_overrun_o, drop the new byte, and keep the held byte unchanged.
  - Otherwise: load rx_data_o and set rx_valid_o=1 on the next edge. Loading and the acceptance of the old byte may occur in the same cycle.
- **Handshake:** rx_valid_o and rx_data_o are stable until the cycle in which rx_valid_o && rx_ready_i. rx_valid_o then clears on the next edge unless a new byte is loaded on that same edge.
- **Error priority:** frame error is checked before parity. Only one err pulse is issued per frame.
- **cfg_en_i=0:** returns to IDLE within 1 cycle with no error pulse. A held byte stays valid.
- **Config stability:** configuration changes mid-frame are undefined except for cfg_en_i. Software changes configuration only while busy_o=0.

Test Plan:
- **Basic 8N1 receive:** div=4, 8N1, send 0xA5 with rx_ready_i=1 after delivery. Required: rx_data_o=0xA5; rx_valid_o rises 611±4 cycles after the line falls; no err pulse.
- **Parity:** div=2, even parity, send 0x3C with parity bit 0 -> delivered 0x3C. Same byte with parity bit 1 -> err_parity_o pulses once, rx_valid_o stays 0. Odd parity with 0x01 and parity bit 0 -> delivered 0x01.
- **Frame error and BREAK:** div=1, 8N1, hold the line at 0 for 200 cycles. Required: err_frame_o pulses once, state stays BREAK until the line is 1, then a following 0x55 frame is received correctly.
- **Glitch rejection:** div=4, 1-cycle low glitch on an idle line. Required: returns to IDLE, no valid, no error. A 2-cycle glitch also yields no output.
- **Overrun and back-to-back:** hold rx_ready_i=0 and send 0x11 then 0x22 back-to-back. Required: rx_data_o stays 0x11 and err_overrun_o pulses once. Then rx_ready_i=1 for one cycle -> rx_valid_o falls; a third byte 0x33 is delivered.
- **Two stop bits and reset mid-frame:** 8N2 with the second stop bit 0 -> err_frame_o pulses. Assert rst during the DATA state of a frame -> all outputs return to reset values; the next clean frame 0x7E is received correctly.
